// File: rtl/slot_bus_pkg.sv
// rtl/slot_bus_pkg.sv - shared state encodings and timing defaults for the slot bus master
package slot_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_ACTIVE  = 3'd2;
  localparam state_t ST_WAITX   = 3'd3;
  localparam state_t ST_HOLD    = 3'd4;
  localparam state_t ST_RECOVER = 3'd5;

  localparam int DEF_T_SETUP      = 1;
  localparam int DEF_T_ACTIVE     = 2;
  localparam int DEF_T_HOLD       = 1;
  localparam int DEF_T_RECOVER    = 1;
  localparam int DEF_WAIT_TIMEOUT = 255;

  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;
  localparam logic [7:0] RD_WRITE_DATA   = 8'h00;

  // Phase counter never wraps, so long waits cannot alias back to a short count.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/slot_bus_master.sv
// rtl/slot_bus_master.sv - initiator turning byte I/O commands into timed slot bus cycles
module slot_bus_master
  import slot_bus_pkg::*;
#(
  parameter int T_SETUP      = DEF_T_SETUP,
  parameter int T_ACTIVE     = DEF_T_ACTIVE,
  parameter int T_HOLD       = DEF_T_HOLD,
  parameter int T_RECOVER    = DEF_T_RECOVER,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic [7:0] slot_a,
  output logic       slot_iorq_n,
  output logic       slot_rd_n,
  output logic       slot_wr_n,
  output logic [7:0] cpu_ff_slot_data,
  output logic       cpu_drive_en,
  input  logic [7:0] slot_d_in,
  input  logic       slot_wait
);

  localparam logic [7:0] SETUP_N   = 8'(T_SETUP);
  localparam logic [7:0] ACTIVE_N  = 8'(T_ACTIVE);
  localparam logic [7:0] HOLD_N    = 8'(T_HOLD);
  localparam logic [7:0] RECOVER_N = 8'(T_RECOVER);
  localparam logic [7:0] TIMEOUT_N = 8'(WAIT_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wait_q;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       ready_q;
  logic       rsp_valid_q, rsp_timeout_q;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0] slot_a_q, dout_q;
  logic       iorq_n_q, rd_n_q, wr_n_q, drive_q;
  logic       accept, last_strobe, timed_out, bus_busy, strobe;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    last_strobe = 1'b0;
    timed_out   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:   if (cnt_q >= SETUP_N) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (cnt_q >= ACTIVE_N) begin
          if (wait_q) begin
            state_d = ST_WAITX;
          end else begin
            last_strobe = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_WAITX: begin
        if (!wait_q) begin
          last_strobe = 1'b1;
          state_d     = ST_HOLD;
        end else if (cnt_q >= TIMEOUT_N) begin
          last_strobe = 1'b1;
          timed_out   = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD:    if (cnt_q >= HOLD_N) state_d = ST_RECOVER;
      ST_RECOVER: if (cnt_q >= RECOVER_N) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    cnt_d   = (state_d != state_q) ? 8'd1 : sat_inc(cnt_q);
    addr_d  = accept ? cmd_addr  : addr_q;
    wdata_d = accept ? cmd_wdata : wdata_q;
    write_d = accept ? cmd_write : write_q;

    // Outputs are decoded from the next state so each registered pin lines up with its phase.
    bus_busy = (state_d == ST_SETUP) || (state_d == ST_ACTIVE) ||
               (state_d == ST_WAITX) || (state_d == ST_HOLD);
    strobe   = (state_d == ST_ACTIVE) || (state_d == ST_WAITX);

    rsp_rdata_d = rsp_rdata_q;
    if (last_strobe) begin
      if (timed_out)    rsp_rdata_d = RD_TIMEOUT_DATA;
      else if (write_q) rsp_rdata_d = RD_WRITE_DATA;
      else              rsp_rdata_d = slot_d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd1;
      wait_q        <= 1'b0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      write_q       <= 1'b0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      slot_a_q      <= 8'h00;
      dout_q        <= 8'h00;
      drive_q       <= 1'b0;
      iorq_n_q      <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= slot_wait;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      ready_q       <= (state_d == ST_IDLE);
      rsp_valid_q   <= last_strobe;
      rsp_timeout_q <= timed_out;
      rsp_rdata_q   <= rsp_rdata_d;
      slot_a_q      <= bus_busy ? addr_d : 8'h00;
      drive_q       <= bus_busy && write_d;
      dout_q        <= (bus_busy && write_d) ? wdata_d : 8'h00;
      iorq_n_q      <= !strobe;
      rd_n_q        <= !(strobe && !write_d);
      wr_n_q        <= !(strobe && write_d);
    end
  end

  assign cmd_ready        = ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign slot_a           = slot_a_q;
  assign slot_iorq_n      = iorq_n_q;
  assign slot_rd_n        = rd_n_q;
  assign slot_wr_n        = wr_n_q;
  assign cpu_ff_slot_data = dout_q;
  assign cpu_drive_en     = drive_q;

endmodule

// File: tb/tb_slot_bus_master.sv
// tb/tb_slot_bus_master.sv - scoreboard bench for the slot bus master
module tb_slot_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata, slot_a, cpu_ff_slot_data, slot_d_in;
  logic       slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en, slot_wait;

  logic       t_cmd_valid, t_cmd_ready, t_cmd_write;
  logic [7:0] t_cmd_addr, t_cmd_wdata;
  logic       t_rsp_valid, t_rsp_timeout;
  logic [7:0] t_rsp_rdata, t_slot_a, t_cpu_ff_slot_data, t_slot_d_in;
  logic       t_slot_iorq_n, t_slot_rd_n, t_slot_wr_n, t_cpu_drive_en, t_slot_wait;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       timeout;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp2_q[$];

  slot_bus_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .slot_a(slot_a), .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .cpu_ff_slot_data(cpu_ff_slot_data), .cpu_drive_en(cpu_drive_en),
    .slot_d_in(slot_d_in), .slot_wait(slot_wait)
  );

  slot_bus_master #(.WAIT_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(t_cmd_write),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
    .slot_a(t_slot_a), .slot_iorq_n(t_slot_iorq_n), .slot_rd_n(t_slot_rd_n), .slot_wr_n(t_slot_wr_n),
    .cpu_ff_slot_data(t_cpu_ff_slot_data), .cpu_drive_en(t_cpu_drive_en),
    .slot_d_in(t_slot_d_in), .slot_wait(t_slot_wait)
  );

  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%02h timeout=%0b, required no response", rsp_rdata, rsp_timeout);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_timeout} !== {e.rdata, e.timeout}) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%02h timeout=%0b, required rdata=%02h timeout=%0b",
                   rsp_rdata, rsp_timeout, e.rdata, e.timeout);
        end
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (t_rsp_valid === 1'b1) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL rsp2_unexpected: got rdata=%02h timeout=%0b, required no response", t_rsp_rdata, t_rsp_timeout);
      end else begin
        e = exp2_q.pop_front();
        if ({t_rsp_rdata, t_rsp_timeout} !== {e.rdata, e.timeout}) begin
          errors++;
          $display("FAIL rsp2_data: got rdata=%02h timeout=%0b, required rdata=%02h timeout=%0b",
                   t_rsp_rdata, t_rsp_timeout, e.rdata, e.timeout);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_ready: got cmd_ready=%0b after 20 cycles, required 1", cmd_ready);
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en, rsp_valid, rsp_timeout, cmd_ready} !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %07b, required 1110000",
               {slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en, rsp_valid, rsp_timeout, cmd_ready});
    end
    checks++;
    if ({slot_a, cpu_ff_slot_data, rsp_rdata} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_data: got a=%02h d=%02h r=%02h, required 00 00 00", slot_a, cpu_ff_slot_data, rsp_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({cmd_ready, t_cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got %02b, required 11", {cmd_ready, t_cmd_ready});
    end
  endtask

  task automatic test_read();
    wait_ready();
    slot_d_in = 8'h5A;
    exp_q.push_back(rsp_t'{rdata: 8'h5A, timeout: 1'b0});
    issue(1'b0, 8'h98, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      logic lo;
      tick();
      if (k == 1) cmd_valid = 1'b0;
      lo = (k >= 2 && k <= 3);
      checks++;
      if ({slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en} !== {!lo, !lo, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL read_strobes c%0d: got %04b, required %04b", k,
                 {slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en}, {!lo, !lo, 1'b1, 1'b0});
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== {k == 4, k == 6}) begin
        errors++;
        $display("FAIL read_handshake c%0d: got valid/ready=%02b, required %02b", k,
                 {rsp_valid, cmd_ready}, {k == 4, k == 6});
      end
      checks++;
      if (slot_a !== ((k <= 4) ? 8'h98 : 8'h00)) begin
        errors++;
        $display("FAIL read_addr c%0d: got %02h, required %02h", k, slot_a, (k <= 4) ? 8'h98 : 8'h00);
      end
    end
  endtask

  task automatic test_write();
    wait_ready();
    exp_q.push_back(rsp_t'{rdata: 8'h00, timeout: 1'b0});
    issue(1'b1, 8'h99, 8'hC3);
    for (int k = 1; k <= 6; k++) begin
      logic lo, dr;
      tick();
      if (k == 1) cmd_valid = 1'b0;
      lo = (k >= 2 && k <= 3);
      dr = (k >= 1 && k <= 4);
      checks++;
      if ({slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en} !== {!lo, 1'b1, !lo, dr}) begin
        errors++;
        $display("FAIL write_strobes c%0d: got %04b, required %04b", k,
                 {slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en}, {!lo, 1'b1, !lo, dr});
      end
      checks++;
      if (cpu_ff_slot_data !== (dr ? 8'hC3 : 8'h00)) begin
        errors++;
        $display("FAIL write_data c%0d: got %02h, required %02h", k, cpu_ff_slot_data, dr ? 8'hC3 : 8'h00);
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== {k == 4, k == 6}) begin
        errors++;
        $display("FAIL write_handshake c%0d: got %02b, required %02b", k, {rsp_valid, cmd_ready}, {k == 4, k == 6});
      end
    end
  endtask

  task automatic test_wait();
    wait_ready();
    slot_d_in = 8'h10;
    exp_q.push_back(rsp_t'{rdata: 8'h18, timeout: 1'b0});
    issue(1'b0, 8'h98, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      logic lo;
      tick();
      if (k == 1) cmd_valid = 1'b0;
      slot_wait = (k >= 2 && k <= 6);
      slot_d_in = 8'(8'h10 + k);
      lo = (k >= 2 && k <= 8);
      checks++;
      if ({slot_iorq_n, slot_rd_n, slot_wr_n} !== {!lo, !lo, 1'b1}) begin
        errors++;
        $display("FAIL wait_strobes c%0d: got %03b, required %03b", k,
                 {slot_iorq_n, slot_rd_n, slot_wr_n}, {!lo, !lo, 1'b1});
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== {k == 9, k == 11}) begin
        errors++;
        $display("FAIL wait_handshake c%0d: got %02b, required %02b", k, {rsp_valid, cmd_ready}, {k == 9, k == 11});
      end
    end
  endtask

  task automatic test_timeout();
    checks++;
    if (t_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready: got %0b, required 1", t_cmd_ready);
    end
    t_slot_wait = 1'b1;
    exp2_q.push_back(rsp_t'{rdata: 8'hFF, timeout: 1'b1});
    t_cmd_write = 1'b0;
    t_cmd_addr  = 8'h98;
    t_cmd_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      logic lo;
      tick();
      if (k == 1) t_cmd_valid = 1'b0;
      lo = (k >= 2 && k <= 7);
      checks++;
      if ({t_slot_iorq_n, t_slot_rd_n, t_slot_wr_n} !== {!lo, !lo, 1'b1}) begin
        errors++;
        $display("FAIL timeout_strobes c%0d: got %03b, required %03b", k,
                 {t_slot_iorq_n, t_slot_rd_n, t_slot_wr_n}, {!lo, !lo, 1'b1});
      end
      checks++;
      if (t_rsp_valid !== (k == 8)) begin
        errors++;
        $display("FAIL timeout_valid c%0d: got %0b, required %0b", k, t_rsp_valid, k == 8);
      end
    end
    checks++;
    if ({t_cmd_ready, t_slot_a, t_cpu_drive_en} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL timeout_idle: got ready=%0b a=%02h drv=%0b, required 1 00 0", t_cmd_ready, t_slot_a, t_cpu_drive_en);
    end
    t_slot_wait = 1'b0;
  endtask

  task automatic test_reset_mid_cycle();
    wait_ready();
    issue(1'b1, 8'h99, 8'h3C);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({slot_iorq_n, slot_wr_n, cpu_drive_en} !== 3'b001) begin
      errors++;
      $display("FAIL midreset_active: got %03b, required 001", {slot_iorq_n, slot_wr_n, cpu_drive_en});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en, rsp_valid, cmd_ready} !== 6'b111000) begin
      errors++;
      $display("FAIL midreset_bus: got %06b, required 111000",
               {slot_iorq_n, slot_rd_n, slot_wr_n, cpu_drive_en, rsp_valid, cmd_ready});
    end
    checks++;
    if ({slot_a, cpu_ff_slot_data} !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_data: got a=%02h d=%02h, required 00 00", slot_a, cpu_ff_slot_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %0b, required 1", cmd_ready);
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    wait_ready();
    slot_d_in = 8'h11;
    exp_q.push_back(rsp_t'{rdata: 8'h11, timeout: 1'b0});
    exp_q.push_back(rsp_t'{rdata: 8'h22, timeout: 1'b0});
    issue(1'b0, 8'h10, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      logic lo;
      tick();
      if (k == 1) issue(1'b0, 8'h20, 8'h00);
      if (k == 7) cmd_valid = 1'b0;
      slot_d_in = (k >= 6) ? 8'h22 : 8'h11;
      lo = (k == 2 || k == 3 || k == 8 || k == 9);
      checks++;
      if ({slot_iorq_n, slot_rd_n, slot_wr_n} !== {!lo, !lo, 1'b1}) begin
        errors++;
        $display("FAIL b2b_strobes c%0d: got %03b, required %03b", k,
                 {slot_iorq_n, slot_rd_n, slot_wr_n}, {!lo, !lo, 1'b1});
      end
      checks++;
      if ({rsp_valid, cmd_ready} !== {k == 4 || k == 10, k == 6 || k == 12}) begin
        errors++;
        $display("FAIL b2b_handshake c%0d: got %02b, required %02b", k,
                 {rsp_valid, cmd_ready}, {k == 4 || k == 10, k == 6 || k == 12});
      end
      if (k == 7) begin
        checks++;
        if (slot_a !== 8'h20) begin
          errors++;
          $display("FAIL b2b_addr: got %02h, required 20", slot_a);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    slot_d_in = 8'h00; slot_wait = 1'b0;
    t_cmd_valid = 1'b0; t_cmd_write = 1'b0; t_cmd_addr = 8'h00; t_cmd_wdata = 8'h00;
    t_slot_d_in = 8'h33; t_slot_wait = 1'b0;

    test_reset();
    test_read();
    test_write();
    test_wait();
    test_timeout();
    test_reset_mid_cycle();
    test_back_to_back();

    repeat (5) tick();
    checks++;
    if (exp_q.size() + exp2_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing: got %0d responses outstanding, required 0", exp_q.size() + exp2_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slot_bus_master.md
Name: slot_bus_master

Overview:
CPU-side initiator for the cartridge slot I/O bus. It is the active end of the protocol that the VDP cartridge answers.
- Turns single-byte command requests (I/O read/write) into timed Z80-style I/O cycles on slot_a, slot_iorq_n, slot_rd_n, slot_wr_n, cpu_ff_slot_data and cpu_drive_en.
- Honours slot_wait.
- Returns read data captured from the resolved slot_d bus.
- Replaces hand-sequenced C++ pin wiggling in the Verilator bench top.

Parameters:
- T_SETUP, 1, cycles address/data valid before strobes fall (>=1)
- T_ACTIVE, 2, minimum cycles strobes held low (>=1)
- T_HOLD, 1, cycles address/data held after strobes rise (>=1)
- T_RECOVER, 1, idle cycles before next command (>=1)
- WAIT_TIMEOUT, 255, maximum extra strobe cycles allowed while slot_wait is high (>=1)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=I/O write, 0=I/O read
- cmd_addr  in  8  I/O port address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid while rsp_valid is high
- rsp_timeout  out  1  qualifies rsp_valid; the cycle was force-terminated
- slot_a  out  8  bus address
- slot_iorq_n  out  1  I/O request strobe, active low
- slot_rd_n  out  1  read strobe, active low
- slot_wr_n  out  1  write strobe, active low
- cpu_ff_slot_data  out  8  data driven onto slot_d
- cpu_drive_en  out  1  enables the bridge drive onto slot_d
- slot_d_in  in  8  resolved value of slot_d
- slot_wait  in  1  active high; extends the strobe phase

Behaviour:
Reset values (applied on the next edge after reset, including mid-cycle):
- slot_iorq_n, slot_rd_n, slot_wr_n = 1
- slot_a = 8'h00, cpu_ff_slot_data = 8'h00, cpu_drive_en = 0
- rsp_valid = 0, rsp_timeout = 0, rsp_rdata = 8'h00
- cmd_ready = 0 during reset; state = IDLE
- A cycle interrupted by reset produces no rsp_valid.

General:
- All bus outputs are registered.
- slot_wait passes through one register stage, wait_q, before use.

State machine:
- IDLE: cmd_ready=1. On accept, latch addr, wdata and write into command registers, then go to SETUP.
- SETUP: T_SETUP cycles.
  - slot_a = addr.
  - For writes: cpu_ff_slot_data = wdata, cpu_drive_en = 1.
  - Strobes stay high.
- ACTIVE: slot_iorq_n = 0, plus slot_rd_n = 0 (read) or slot_wr_n = 0 (write). Address and data are held.
  - Runs a minimum of T_ACTIVE cycles.
  - After the minimum, if wait_q = 1, enter WAITX; otherwise this is the last strobe cycle.
- WAITX: strobes stay low. Exit on the first cycle with wait_q = 0, or after WAIT_TIMEOUT cycles in WAITX.
- On the last strobe cycle (ACTIVE or WAITX), capture read data into rsp_rdata:
  - normal read: slot_d_in
  - write: 8'h00
  - timeout: 8'hFF
- HOLD: T_HOLD cycles. Strobes high; slot_a and cpu_drive_en/data unchanged.
  - On the first HOLD cycle: rsp_valid = 1, and rsp_timeout = 1 if the cycle timed out.
- RECOVER: T_RECOVER cycles. cpu_drive_en = 0, slot_a = 8'h00, cmd_ready = 0. Then IDLE.

Rules and boundary conditions:
- slot_rd_n and slot_wr_n are never low simultaneously.
- cpu_drive_en is never 1 during a read.
- cmd_valid is ignored outside IDLE; it does not need to be held for more than one cycle.
- Phase counter is 8 bits and saturates; WAIT_TIMEOUT counting starts at 1 on WAITX entry.
- wait_q rising after the last ACTIVE cycle has been decided has no effect.
- Default latency, no wait: accept at cycle 0, SETUP at 1, ACTIVE at 2–3, HOLD/rsp_valid at 4, RECOVER at 5, cmd_ready again at 6.

Decomposition:
- slot_bus_pkg holds:
  - state enum (IDLE, SETUP, ACTIVE, WAITX, HOLD, RECOVER)
  - default timing constants
  - constant RD_TIMEOUT_DATA = 8'hFF
- Single module, no sub-module.
- wait_q register and phase counter are inline.

Test Plan:
- Read port 8'h98 (defaults, wait=0, slot_d_in=8'h5A) -> strobes low cycles 2–3, rsp_valid at cycle 4 with rdata=8'h5A, rsp_timeout=0, cpu_drive_en=0 throughout.
- Write 8'h99 data 8'hC3 -> cpu_drive_en=1 and data=8'hC3 from cycle 1 through 4, slot_wr_n low cycles 2–3, rsp_rdata=8'h00, cmd_ready at cycle 6.
- Read with slot_wait high for 5 cycles starting at cycle 2 -> strobe phase extended by 5 (including one cycle of wait_q lag), data captured on the last low cycle, single rsp_valid.
- slot_wait stuck high, WAIT_TIMEOUT=4 -> WAITX exits after 4 cycles, rsp_timeout=1, rsp_rdata=8'hFF, bus returns to idle.
- Reset asserted during ACTIVE of a write -> all strobes high and cpu_drive_en=0 after the next edge, no rsp_valid, cmd_ready after reset release.
- Back-to-back commands with cmd_valid held -> second accepted exactly on the first IDLE cycle; at least T_RECOVER idle cycles between strobe phases.
